// File: rtl/mp_bus_pkg.sv
// Shared types and defaults for the multiprocessor memory-port arbiter.
package mp_bus_pkg;

    localparam int unsigned NumCoresDefault = 4;
    localparam int unsigned BurstLenDefault = 4;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_BRD = 2'b10,
        OP_BWR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    function automatic logic op_is_write(input op_e op);
        return op[0];
    endfunction

    function automatic logic op_is_burst(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: rotate requests by the pointer, take the
// lowest set bit, rotate the index back.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] rr_ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o
);

    logic [2*N-1:0]  req_dbl;
    logic [N-1:0]    req_rot;
    logic [IdxW-1:0] pick;
    logic [IdxW:0]   sum;

    always_comb begin
        req_dbl = {req_i, req_i};
        req_rot = req_dbl[rr_ptr_i +: N];
        pick    = '0;
        // Descending scan so the lowest rotated position wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick = IdxW'(i);
            end
        end
        sum = {1'b0, pick} + {1'b0, rr_ptr_i};
        if (sum >= (IdxW + 1)'(N)) begin
            sum = sum - (IdxW + 1)'(N);
        end
        gnt_idx_o = sum[IdxW-1:0];
        gnt_o     = (|req_i) ? (N'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/mp_bus_arbiter.sv
// Round-robin sequencer sharing one memory port among several cores, with
// burst address generation and in-order read-data routing.
module mp_bus_arbiter
    import mp_bus_pkg::*;
#(
    parameter int unsigned NUM_CORES = NumCoresDefault,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = BurstLenDefault,
    localparam int unsigned IdW      = $clog2(NUM_CORES)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CORES-1:0]      req,
    input  logic [NUM_CORES*2-1:0]    opcode,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] data_in,
    output logic [NUM_CORES-1:0]      gnt,
    output logic [DATA_W-1:0]         data_out,
    output logic [NUM_CORES-1:0]      rvalid,
    output logic [IdW-1:0]            core_id,
    output logic [2:0]                burst_id,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic                      mem_rvalid,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      protocol_err
);

    localparam int unsigned OutW  = $clog2(BURST_LEN + 1);
    localparam int unsigned BeatW = 4;

    logic [1:0]        op_arr   [NUM_CORES];
    logic [ADDR_W-1:0] addr_arr [NUM_CORES];
    logic [DATA_W-1:0] data_arr [NUM_CORES];

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            op_arr[i]   = opcode[2*i +: 2];
            addr_arr[i] = addr[ADDR_W*i +: ADDR_W];
            data_arr[i] = data_in[DATA_W*i +: DATA_W];
        end
    end

    state_e              state_q, state_d;
    logic [IdW-1:0]      owner_q, owner_d;
    logic                is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BeatW-1:0]    beats_q, beats_d;
    logic [BeatW-1:0]    issue_idx_q, issue_idx_d;
    logic [2:0]          ret_idx_q, ret_idx_d;
    logic [OutW-1:0]     outstanding_q, outstanding_d;
    logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [NUM_CORES-1:0] rvalid_q, rvalid_d;
    logic [IdW-1:0]      core_id_q, core_id_d;
    logic [2:0]          burst_id_q, burst_id_d;
    logic                perr_q, perr_d;

    logic [NUM_CORES-1:0] win_onehot;
    logic [IdW-1:0]       win_idx;
    logic                 beat_pend;
    logic                 issue_fire;
    logic                 ret_fire;
    logic                 last_beat;
    logic [IdW-1:0]       rr_next;
    op_e                  win_op;

    rr_arbiter #(
        .N (NUM_CORES)
    ) u_rr_arbiter (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (win_onehot),
        .gnt_idx_o (win_idx)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        is_wr_d       = is_wr_q;
        base_d        = base_q;
        beats_d       = beats_q;
        issue_idx_d   = issue_idx_q;
        ret_idx_d     = ret_idx_q;
        rr_ptr_d      = rr_ptr_q;
        data_out_d    = data_out_q;
        rvalid_d      = '0;
        core_id_d     = core_id_q;
        burst_id_d    = burst_id_q;
        win_op        = op_e'(op_arr[win_idx]);
        beat_pend     = issue_idx_q < beats_q;
        issue_fire    = (state_q == StIssue) && mem_ready && beat_pend;
        ret_fire      = mem_rvalid && (outstanding_q != '0);
        last_beat     = issue_idx_q == beats_q - BeatW'(1);
        rr_next       = (owner_q == IdW'(NUM_CORES - 1)) ? '0 : owner_q + IdW'(1);
        perr_d        = mem_rvalid && (outstanding_q == '0);

        // Issue and return in the same cycle cancel out.
        outstanding_d = outstanding_q;
        if (issue_fire && !is_wr_q) begin
            outstanding_d = outstanding_d + OutW'(1);
        end
        if (ret_fire) begin
            outstanding_d = outstanding_d - OutW'(1);
            data_out_d    = mem_rdata;
            rvalid_d      = NUM_CORES'(1) << owner_q;
            core_id_d     = owner_q;
            burst_id_d    = ret_idx_q;
            ret_idx_d     = ret_idx_q + 3'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (|win_onehot) begin
                    owner_d     = win_idx;
                    is_wr_d     = op_is_write(win_op);
                    base_d      = addr_arr[win_idx];
                    beats_d     = op_is_burst(win_op) ? BeatW'(BURST_LEN) : BeatW'(1);
                    issue_idx_d = '0;
                    ret_idx_d   = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (issue_fire) begin
                    issue_idx_d = issue_idx_q + BeatW'(1);
                    if (last_beat) begin
                        if (is_wr_q || (outstanding_d == '0)) begin
                            state_d  = StIdle;
                            rr_ptr_d = rr_next;
                        end else begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                if (outstanding_d == '0) begin
                    state_d  = StIdle;
                    rr_ptr_d = rr_next;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            owner_q       <= '0;
            is_wr_q       <= 1'b0;
            base_q        <= '0;
            beats_q       <= '0;
            issue_idx_q   <= '0;
            ret_idx_q     <= '0;
            outstanding_q <= '0;
            rr_ptr_q      <= '0;
            data_out_q    <= '0;
            rvalid_q      <= '0;
            core_id_q     <= '0;
            burst_id_q    <= '0;
            perr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            is_wr_q       <= is_wr_d;
            base_q        <= base_d;
            beats_q       <= beats_d;
            issue_idx_q   <= issue_idx_d;
            ret_idx_q     <= ret_idx_d;
            outstanding_q <= outstanding_d;
            rr_ptr_q      <= rr_ptr_d;
            data_out_q    <= data_out_d;
            rvalid_q      <= rvalid_d;
            core_id_q     <= core_id_d;
            burst_id_q    <= burst_id_d;
            perr_q        <= perr_d;
        end
    end

    // Request side is gated by state so everything reads zero outside ISSUE.
    always_comb begin
        mem_req      = (state_q == StIssue);
        mem_we       = mem_req && is_wr_q;
        mem_addr     = mem_req ? (base_q + ADDR_W'(issue_idx_q)) : '0;
        mem_wdata    = mem_req ? data_arr[owner_q] : '0;
        gnt          = issue_fire ? (NUM_CORES'(1) << owner_q) : '0;
        data_out     = data_out_q;
        rvalid       = rvalid_q;
        core_id      = core_id_q;
        burst_id     = burst_id_q;
        protocol_err = perr_q;
    end

endmodule

// File: tb/tb_mp_bus_arbiter.sv
// Directed self-checking bench for mp_bus_arbiter (4 cores, 16-bit addr, 32-bit data).
module tb_mp_bus_arbiter;
    import mp_bus_pkg::*;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req;
    logic [7:0]   opcode;
    logic [63:0]  addr;
    logic [127:0] data_in;
    logic [3:0]   gnt;
    logic [31:0]  data_out;
    logic [3:0]   rvalid;
    logic [1:0]   core_id;
    logic [2:0]   burst_id;
    logic         mem_req;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ready;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         protocol_err;

    int n_checks = 0;
    int n_fail   = 0;
    int gcnt;
    logic [3:0] exp_gnt [5];

    mp_bus_arbiter #(
        .NUM_CORES (4),
        .ADDR_W    (16),
        .DATA_W    (32),
        .BURST_LEN (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .opcode       (opcode),
        .addr         (addr),
        .data_in      (data_in),
        .gnt          (gnt),
        .data_out     (data_out),
        .rvalid       (rvalid),
        .core_id      (core_id),
        .burst_id     (burst_id),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req        = '0;
        opcode     = '0;
        addr       = '0;
        data_in    = '0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_perr", 32'(protocol_err), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);

        // Unsolicited return while idle
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step();
        check_eq("unsol_perr", 32'(protocol_err), 32'd1);
        check_eq("unsol_rvalid", 32'(rvalid), 32'd0);
        mem_rvalid = 1'b0;
        step();
        check_eq("unsol_perr_clr", 32'(protocol_err), 32'd0);

        // Single read, no contention
        do_reset();
        req[0]         = 1'b1;
        opcode[1:0]    = 2'b00;
        addr[15:0]     = 16'h0010;
        step();
        check_eq("rd_mem_req", 32'(mem_req), 32'd1);
        check_eq("rd_mem_addr", 32'(mem_addr), 32'h0010);
        check_eq("rd_mem_we", 32'(mem_we), 32'd0);
        check_eq("rd_gnt", 32'(gnt), 32'h1);
        req = '0;
        step();
        check_eq("rd_drain_req", 32'(mem_req), 32'd0);
        check_eq("rd_drain_gnt", 32'(gnt), 32'd0);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        check_eq("rd_rvalid", 32'(rvalid), 32'h1);
        check_eq("rd_data", data_out, 32'hDEAD_BEEF);
        check_eq("rd_core_id", 32'(core_id), 32'd0);
        check_eq("rd_burst_id", 32'(burst_id), 32'd0);
        check_eq("rd_perr", 32'(protocol_err), 32'd0);
        mem_rvalid = 1'b0;
        step();
        check_eq("rd_rvalid_clr", 32'(rvalid), 32'd0);

        // Full contention, single writes held
        do_reset();
        exp_gnt = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        for (int c = 0; c < 4; c++) begin
            opcode[2*c +: 2]   = 2'b01;
            addr[16*c +: 16]   = 16'h0020 + 16'(c);
            data_in[32*c +: 32] = 32'h0000_00A0 + 32'(c);
        end
        req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            step();
            check_eq("ctn_gnt", 32'(gnt), 32'(exp_gnt[n]));
            check_eq("ctn_addr", 32'(mem_addr), 32'h0020 + 32'(n % 4));
            check_eq("ctn_wdata", mem_wdata, 32'h0000_00A0 + 32'(n % 4));
            check_eq("ctn_we", 32'(mem_we), 32'd1);
            if (n == 4) req = '0;
            step();
            check_eq("ctn_idle_gap", 32'(mem_req), 32'd0);
        end

        // Burst write with a 3-cycle stall on beat 1
        do_reset();
        req[2]         = 1'b1;
        opcode[5:4]    = 2'b11;
        addr[47:32]    = 16'h0100;
        gcnt           = 0;
        step();
        for (int b = 0; b < 4; b++) begin
            data_in[95:64] = 32'h0000_1000 + 32'(b);
            if (b == 1) begin
                mem_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    settle();
                    check_eq("bwr_stall_gnt", 32'(gnt), 32'd0);
                    check_eq("bwr_stall_addr", 32'(mem_addr), 32'h0101);
                    check_eq("bwr_stall_wdata", mem_wdata, 32'h0000_1001);
                    step();
                end
                mem_ready = 1'b1;
            end
            settle();
            check_eq("bwr_addr", 32'(mem_addr), 32'h0100 + 32'(b));
            check_eq("bwr_wdata", mem_wdata, 32'h0000_1000 + 32'(b));
            check_eq("bwr_we", 32'(mem_we), 32'd1);
            check_eq("bwr_gnt", 32'(gnt), 32'h4);
            if (gnt[2]) gcnt++;
            if (b == 3) req = '0;
            step();
        end
        check_eq("bwr_gnt_count", 32'(gcnt), 32'd4);
        check_eq("bwr_done", 32'(mem_req), 32'd0);

        // Burst read at 0xFFFE with returns overlapping issue
        do_reset();
        req[3]         = 1'b1;
        opcode[7:6]    = 2'b10;
        addr[63:48]    = 16'hFFFE;
        step();
        check_eq("brd_addr0", 32'(mem_addr), 32'hFFFE);
        check_eq("brd_gnt0", 32'(gnt), 32'h8);
        check_eq("brd_we", 32'(mem_we), 32'd0);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_00B0;
        settle();
        check_eq("brd_addr1", 32'(mem_addr), 32'hFFFF);
        check_eq("brd_gnt1", 32'(gnt), 32'h8);
        step();
        check_eq("brd_rv0", 32'(rvalid), 32'h8);
        check_eq("brd_bid0", 32'(burst_id), 32'd0);
        check_eq("brd_data0", data_out, 32'h0000_00B0);
        mem_rdata = 32'h0000_00B1;
        settle();
        check_eq("brd_addr2", 32'(mem_addr), 32'h0000);
        step();
        check_eq("brd_bid1", 32'(burst_id), 32'd1);
        check_eq("brd_data1", data_out, 32'h0000_00B1);
        mem_rvalid = 1'b0;
        req        = '0;
        settle();
        check_eq("brd_addr3", 32'(mem_addr), 32'h0001);
        check_eq("brd_gnt3", 32'(gnt), 32'h8);
        step();
        check_eq("brd_drain_req", 32'(mem_req), 32'd0);
        check_eq("brd_drain_rv", 32'(rvalid), 32'd0);
        // A waiting core only gets in once the last return has drained.
        req[0]      = 1'b1;
        opcode[1:0] = 2'b01;
        addr[15:0]  = 16'h0030;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'h0000_00B2;
        step();
        check_eq("brd_bid2", 32'(burst_id), 32'd2);
        check_eq("brd_data2", data_out, 32'h0000_00B2);
        check_eq("brd_still_drain", 32'(mem_req), 32'd0);
        mem_rdata = 32'h0000_00B3;
        step();
        check_eq("brd_rv3", 32'(rvalid), 32'h8);
        check_eq("brd_bid3", 32'(burst_id), 32'd3);
        check_eq("brd_cid3", 32'(core_id), 32'd3);
        check_eq("brd_data3", data_out, 32'h0000_00B3);
        check_eq("brd_idle_after4", 32'(mem_req), 32'd0);
        mem_rvalid = 1'b0;
        step();
        check_eq("brd_next_req", 32'(mem_req), 32'd1);
        check_eq("brd_next_addr", 32'(mem_addr), 32'h0030);
        check_eq("brd_next_gnt", 32'(gnt), 32'h1);
        req = '0;
        step();
        check_eq("brd_next_done", 32'(mem_req), 32'd0);

        // Reset in the middle of a burst read
        do_reset();
        req[1]      = 1'b1;
        opcode[3:2] = 2'b10;
        addr[31:16] = 16'h0200;
        step();
        check_eq("mrst_gnt0", 32'(gnt), 32'h2);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0055;
        settle();
        check_eq("mrst_addr1", 32'(mem_addr), 32'h0201);
        step();
        mem_rvalid = 1'b0;
        settle();
        check_eq("mrst_data_pre", data_out, 32'h0000_0055);
        check_eq("mrst_addr2", 32'(mem_addr), 32'h0202);
        reset_n = 1'b0;
        #1;
        check_eq("mrst_mem_req", 32'(mem_req), 32'd0);
        check_eq("mrst_gnt", 32'(gnt), 32'd0);
        check_eq("mrst_addr", 32'(mem_addr), 32'd0);
        check_eq("mrst_data", data_out, 32'd0);
        check_eq("mrst_rvalid", 32'(rvalid), 32'd0);
        req = '0;
        step();
        reset_n = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0066;
        step();
        check_eq("mrst_late_perr", 32'(protocol_err), 32'd1);
        check_eq("mrst_late_rvalid", 32'(rvalid), 32'd0);
        mem_rvalid = 1'b0;
        step();
        check_eq("mrst_perr_clr", 32'(protocol_err), 32'd0);
        // Pointer back at 0: core 1 beats core 2.
        opcode[3:2] = 2'b01;
        opcode[5:4] = 2'b01;
        req         = 4'b0110;
        step();
        check_eq("mrst_rr_ptr", 32'(gnt), 32'h2);
        req = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mp_bus_arbiter.md
# mp_bus_arbiter

Round-robin arbiter and sequencer that shares one memory port among `NUM_CORES` processor cores in the multiprocessor system. It accepts single and 4-beat burst read/write requests from each core and grants exactly one core at a time. It drives the shared memory handshake, including per-beat address generation, and routes in-order read data back to the owning core, tagged with `core_id` and `burst_id`. It sits between the core-side request interface and the memory model/controller.

## Interface
- `NUM_CORES`, 4: number of requesting cores (≥2).
- `ADDR_W`, 16: word address width.
- `DATA_W`, 32: data width.
- `BURST_LEN`, 4: beats per burst opcode (power of two, ≤8).
- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NUM_CORES: per-core request, held until the final beat's `gnt`.
- `opcode` in NUM_CORES×2: per core; 00 read, 01 write, 10 burst read, 11 burst write. Stable while `req` is high.
- `addr` in NUM_CORES×ADDR_W: per-core base word address, stable while `req` is high.
- `data_in` in NUM_CORES×DATA_W: per-core write data. The next beat is presented the cycle after each `gnt`.
- `gnt` out NUM_CORES: one-hot; pulses once per accepted beat.
- `data_out` out DATA_W: read data to cores (shared bus).
- `rvalid` out NUM_CORES: one-hot; qualifies `data_out` for the owner.
- `core_id` out clog2(NUM_CORES): owner of the current `rvalid` beat.
- `burst_id` out 3: beat index of the current `rvalid` beat (0 for single).
- `mem_req`, `mem_we` out 1: memory request and write enable.
- `mem_addr` out ADDR_W; `mem_wdata` out DATA_W.
- `mem_ready` in 1: memory accepts the beat when `mem_req && mem_ready`.
- `mem_rvalid` in 1; `mem_rdata` in DATA_W: in-order read return, any latency ≥1.
- `protocol_err` out 1: one-cycle pulse on an unsolicited `mem_rvalid`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- **IDLE:**
  - If any `req` is high, select the winner by round-robin, searching from `rr_ptr` upward with wrap.
  - Latch the owner, opcode, base address and beat count (1 or `BURST_LEN`). Go to ISSUE.
  - `req` is sampled only in IDLE.
- **ISSUE:**
  - `mem_req`=1.
  - `mem_addr` = base + beat index, modulo 2^ADDR_W, so it wraps 0xFFFF→0x0000.
  - `mem_we` = opcode[0].
  - `mem_wdata` = `data_in[owner]`.
  - On each accepted beat: `gnt[owner]`=1, the beat index increments, and for reads `outstanding`+1.
  - After the last accepted beat:
    - For a write, go to IDLE.
    - For a read, go to DRAIN, or directly to IDLE if `outstanding` reaches 0 in the same cycle.
- **DRAIN:** wait until `outstanding`==0, then go to IDLE.
- `rr_ptr` loads (owner+1) mod NUM_CORES on the transition to IDLE.
- **Read return:**
  - Each `mem_rvalid` with `outstanding`>0 decrements `outstanding`.
  - It registers `data_out`=`mem_rdata`, `rvalid[owner]`=1, `core_id`=owner and `burst_id`=return index. The return index is separate from the issue index.
  - A simultaneous issue and return in one cycle changes `outstanding` by net 0.
- `mem_rvalid` with `outstanding`==0 is ignored, and `protocol_err` pulses the next cycle.
- A core that still holds `req` after completion is treated as a new request and competes normally. `rr_ptr` guarantees it goes behind the other requesters.

## Timing
- **Reset values:**
  - All outputs 0 and state IDLE.
  - `rr_ptr`=0, `outstanding`=0 and the beat indices are 0.
  - Reset mid-transaction abandons it. Reads still in flight are not tracked after reset; any later return raises `protocol_err`.
- Arbitration takes one cycle: a `req` seen at edge k gives `mem_req` high from edge k+1.
- `gnt` is combinational: `gnt[owner]` = ISSUE && `mem_ready` && beat pending.
- `mem_*` request outputs come from registered state. `mem_wdata` passes `data_in[owner]` combinationally.
- `mem_ready` low stalls the beat. Address and data hold, and no `gnt` is issued.
- Read data latency: `rvalid` arrives one cycle after `mem_rvalid`.
- Back-to-back transactions: minimum one IDLE cycle between owners.
- `outstanding` width is clog2(BURST_LEN+1) and never exceeds BURST_LEN.

## Structure
- Package `mp_bus_pkg`: opcode enum (`OP_RD`, `OP_WR`, `OP_BRD`, `OP_BWR`), FSM state enum, and the default `NUM_CORES`/`BURST_LEN` constants. The testbench transaction class shares this package.
- Sub-module `rr_arbiter`: combinational rotate-priority-rotate. Inputs are `req` and `rr_ptr`; outputs are a one-hot winner and its index.

## Test plan
- **Single read, no contention:**
  - Stimulus: core 0 reads addr 0x0010; memory returns 0xDEADBEEF after 2 cycles.
  - Response: one `gnt[0]`; `rvalid[0]` with `data_out`=0xDEADBEEF, `core_id`=0, `burst_id`=0.
- **Full contention:**
  - Stimulus: all four cores assert single writes together with `req` held.
  - Response: grant order 0,1,2,3,0; `rr_ptr` cycles.
- **Burst write under stall:**
  - Stimulus: core 2 burst-writes at 0x0100; `mem_ready` low on beat 1 for 3 cycles.
  - Response: `mem_addr` is 0x0100–0x0103 in order with `mem_wdata` stable during the stall; exactly 4 `gnt[2]` pulses.
- **Burst read with address wrap:**
  - Stimulus: core 3 burst-reads at 0xFFFE; returns overlap with issue.
  - Response: `mem_addr` is 0xFFFE, 0xFFFF, 0x0000, 0x0001; `burst_id` is 0–3 on `rvalid[3]`; state reaches IDLE only after the 4th return.
- **Reset mid-burst:**
  - Stimulus: assert `reset_n`=0 during beat 2 of a burst read.
  - Response: all outputs are 0 immediately and `rr_ptr`=0; a late `mem_rvalid` pulses `protocol_err` with no `rvalid`.
- **Unsolicited return:**
  - Stimulus: `mem_rvalid` while IDLE.
  - Response: `protocol_err` pulses for one cycle; `rvalid` stays 0.
